cuckoo_lookup: RTL and testbench
================================

# cuckoo_lookup

Read side of the two-table cuckoo hash store: accepts a key lookup, probes table 1 at `h1(key)` and then table 2 at `h2(key)`, and returns hit/miss, the hitting table and the slot index. Sits beside the insert path, sharing the hash functions. Has its own synchronous read port on each table's storage and never writes either table.

## Interface
- `KEY_W`, 32: key/entry width.
- `IDX_W`, 5: slot index width; each table holds `2**IDX_W` slots.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: lookup request present.
- `req_ready`  out  1: block can accept a request; high only in IDLE.
- `req_key`  in  KEY_W: key to find; sampled on the accept edge.
- `t1_rd_en`, `t2_rd_en`  out  1: table read strobes.
- `t1_raddr`, `t2_raddr`  out  IDX_W: read addresses.
- `t1_rdata`, `t2_rdata`  in  KEY_W: stored entry; valid the cycle after the strobe.
- `t1_rfilled`, `t2_rfilled`  in  1: slot-occupied flag; same timing as rdata.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer takes the response.
- `rsp_hit`  out  1: key found.
- `rsp_tbl`  out  1: 0 = table 1, 1 = table 2; 0 on miss.
- `rsp_idx`  out  IDX_W: slot of the hit; 0 on miss.

## Operation
- States: IDLE, RD1, CHK1, RD2, CHK2, RESP.
- IDLE: `req_ready=1`. On `req_valid` the key is latched into `key_q` and the FSM goes to RD1.
- RD1: `t1_rd_en=1` and `t1_raddr=h1(key_q)` for one cycle. Goes to CHK1.
- CHK1: if `t1_rfilled && t1_rdata==key_q`, set hit=1, tbl=0, idx=h1, then go to RESP. Otherwise go to RD2.
- RD2: `t2_rd_en=1` and `t2_raddr=h2(key_q)`. Goes to CHK2.
- CHK2: if `t2_rfilled && t2_rdata==key_q`, set hit=1, tbl=1, idx=h2. Otherwise set hit=0, tbl=0, idx=0. Goes to RESP.
- RESP: `rsp_valid=1`. rsp fields are held stable until `rsp_ready`. The FSM returns to IDLE on the `rsp_valid && rsp_ready` edge.
- Empty slot: when the filled flag is 0, data is ignored, even if it equals the key.
- Key 0 is a legal key; it matches only a filled slot.
- `h1(k)`: XOR of the six 5-bit chunks `k[29:0]`.
- `h2(k)`: bits `[31:27]` of the 32-bit truncated product `k*32'h9E3779B1`.
- Example: key 5 gives h1=5 and h2=2.
- Read enables are low in every state other than RD1 and RD2. Addresses are 0 when the matching enable is low.

## Timing
- All outputs are registered.
- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_hit=0`, `rsp_tbl=0`, `rsp_idx=0`, both `rd_en=0`, both `raddr=0`, FSM=IDLE.
- Latency, counted from the accept edge (cycle 0) to the first cycle with `rsp_valid` high:
  - table-1 hit: 3 cycles;
  - table-2 hit or miss: 5 cycles.
- Throughput: one lookup in flight at a time; `req_ready` is low from RD1 through RESP.
- Back-to-back: the earliest next accept is the cycle after the response handshake.
- Backpressure: the response stalls in RESP indefinitely with no field changes.
- Concurrent writes: if the insert path writes a slot between this block's probes, the result reflects the data sampled at each probe. No atomicity is provided; the system guarantees no writes during a lookup.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs take their reset values; the in-flight lookup is dropped with no response.

## Configuration
- `CUCKOO_LOOKUP_STATS_EN` defined: adds outputs `stat_hits` and `stat_misses`, each 16 bits.
  - Each counter increments by 1 on the response handshake of a hit or a miss respectively.
  - Counters saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `cuckoo_pkg` holds:
  - default `KEY_W` and `IDX_W`;
  - the `h2` multiplier constant;
  - functions `h1` and `h2`, also used by the insert path;
  - the FSM state enum.
- Sub-module `cuckoo_probe_cmp`: combinational compare of filled/rdata against the key. One instance is used per table.

## Test plan
- Table 1 slot 5 filled with 5, key 5 requested → `rsp_valid` at cycle 3 with hit=1, tbl=0, idx=5; `t2_rd_en` never asserted.
- Table 1 slot 5 holds 7, table 2 slot 2 filled with 5, key 5 → `rsp_valid` at cycle 5 with hit=1, tbl=1, idx=2.
- Both tables empty, key 5 → hit=0, tbl=0, idx=0 at cycle 5.
- Table 1 slot 5 data 5 with filled=0, table 2 empty → miss.
- `rsp_ready` held low for 10 cycles → response stable, `req_ready` low; the next request is accepted on the cycle after the handshake.
- `rst_n` pulsed low during CHK1 → outputs at reset values, no `rsp_valid`. With `CUCKOO_LOOKUP_STATS_EN`, 2 hits and 1 miss give `stat_hits=2` and `stat_misses=1`.

Source files
------------

// File: rtl/cuckoo_pkg.sv
// cuckoo_pkg: shared hash functions, defaults and lookup FSM states for the cuckoo store.
package cuckoo_pkg;
    localparam int KEY_W_DEF = 32;
    localparam int IDX_W_DEF = 5;
    localparam logic [31:0] H2_MUL = 32'h9E3779B1;
    typedef enum logic [2:0] {IDLE, RD1, CHK1, RD2, CHK2, RESP} state_t;
    function automatic logic [IDX_W_DEF-1:0] h1(input logic [KEY_W_DEF-1:0] k);
        return k[4:0] ^ k[9:5] ^ k[14:10] ^ k[19:15] ^ k[24:20] ^ k[29:25];
    endfunction
    // Multiplicative hash: top bits of the truncated product.
    function automatic logic [IDX_W_DEF-1:0] h2(input logic [KEY_W_DEF-1:0] k);
        logic [31:0] p;
        p = k * H2_MUL;
        return p[31:27];
    endfunction
endpackage

// File: rtl/cuckoo_probe_cmp.sv
// cuckoo_probe_cmp: a probed slot matches only when occupied and its entry equals the key.
module cuckoo_probe_cmp #(
    parameter int KEY_W = 32
) (
    input  logic             filled,
    input  logic [KEY_W-1:0] rdata,
    input  logic [KEY_W-1:0] key,
    output logic             match
);
    assign match = filled && (rdata == key);
endmodule

// File: rtl/cuckoo_lookup.sv
// cuckoo_lookup: two-probe key lookup over the cuckoo tables, all outputs registered.
// Define CUCKOO_LOOKUP_STATS_EN to add saturating hit/miss counters.
module cuckoo_lookup
    import cuckoo_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    output logic             t1_rd_en,
    output logic [IDX_W-1:0] t1_raddr,
    input  logic [KEY_W-1:0] t1_rdata,
    input  logic             t1_rfilled,
    output logic             t2_rd_en,
    output logic [IDX_W-1:0] t2_raddr,
    input  logic [KEY_W-1:0] t2_rdata,
    input  logic             t2_rfilled,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_tbl,
`ifdef CUCKOO_LOOKUP_STATS_EN
    output logic [15:0]      stat_hits,
    output logic [15:0]      stat_misses,
`endif
    output logic [IDX_W-1:0] rsp_idx
);
    state_t           state, state_n;
    logic [KEY_W-1:0] key_q, key_n;
    logic             hit_n, tbl_n, m1, m2;
    logic [IDX_W-1:0] idx_n;

    cuckoo_probe_cmp #(.KEY_W(KEY_W)) u_cmp1 (.filled(t1_rfilled), .rdata(t1_rdata), .key(key_q), .match(m1));
    cuckoo_probe_cmp #(.KEY_W(KEY_W)) u_cmp2 (.filled(t2_rfilled), .rdata(t2_rdata), .key(key_q), .match(m2));

    always_comb begin
        state_n = state;
        key_n   = key_q;
        hit_n   = rsp_hit;
        tbl_n   = rsp_tbl;
        idx_n   = rsp_idx;
        case (state)
            IDLE: if (req_valid) begin
                key_n   = req_key;
                state_n = RD1;
            end
            RD1:  state_n = CHK1;
            CHK1: if (m1) begin
                hit_n   = 1'b1;
                tbl_n   = 1'b0;
                idx_n   = h1(key_q);
                state_n = RESP;
            end else begin
                state_n = RD2;
            end
            RD2:  state_n = CHK2;
            CHK2: begin
                hit_n   = m2;
                tbl_n   = m2;
                idx_n   = m2 ? h2(key_q) : '0;
                state_n = RESP;
            end
            RESP: if (rsp_ready) begin
                hit_n   = 1'b0;
                tbl_n   = 1'b0;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_q     <= '0;
            req_ready <= 1'b1;
            t1_rd_en  <= 1'b0;
            t1_raddr  <= '0;
            t2_rd_en  <= 1'b0;
            t2_raddr  <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_tbl   <= 1'b0;
            rsp_idx   <= '0;
        end else begin
            state     <= state_n;
            key_q     <= key_n;
            req_ready <= state_n == IDLE;
            t1_rd_en  <= state_n == RD1;
            t1_raddr  <= state_n == RD1 ? h1(key_n) : '0;
            t2_rd_en  <= state_n == RD2;
            t2_raddr  <= state_n == RD2 ? h2(key_n) : '0;
            rsp_valid <= state_n == RESP;
            rsp_hit   <= hit_n;
            rsp_tbl   <= tbl_n;
            rsp_idx   <= idx_n;
        end
    end

`ifdef CUCKOO_LOOKUP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
            if (!rsp_hit && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cuckoo_lookup.sv
// tb_cuckoo_lookup: directed lookups against table stubs, checked by a transaction-level latency model.
module tb_cuckoo_lookup;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready, rsp_ready = 0;
    logic [31:0] req_key = 0;
    logic        t1_rd_en, t2_rd_en, t1_rfilled = 0, t2_rfilled = 0;
    logic [4:0]  t1_raddr, t2_raddr, rsp_idx;
    logic [31:0] t1_rdata = 0, t2_rdata = 0;
    logic        rsp_valid, rsp_hit, rsp_tbl;
    logic [31:0] t1_mem [32], t2_mem [32];
    logic        t1_fill [32], t2_fill [32];
    int          vec = 0, errs = 0;
`ifdef CUCKOO_LOOKUP_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    cuckoo_lookup dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .t1_rd_en(t1_rd_en), .t1_raddr(t1_raddr), .t1_rdata(t1_rdata), .t1_rfilled(t1_rfilled),
        .t2_rd_en(t2_rd_en), .t2_raddr(t2_raddr), .t2_rdata(t2_rdata), .t2_rfilled(t2_rfilled),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_tbl(rsp_tbl),
`ifdef CUCKOO_LOOKUP_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
        .rsp_idx(rsp_idx)
    );

    always #5 clk = ~clk;

    // Table storage stubs with one-cycle read latency.
    always @(posedge clk) begin
        if (t1_rd_en) begin t1_rdata <= t1_mem[t1_raddr]; t1_rfilled <= t1_fill[t1_raddr]; end
        if (t2_rd_en) begin t2_rdata <= t2_mem[t2_raddr]; t2_rfilled <= t2_fill[t2_raddr]; end
    end

    function automatic logic [4:0] m_h1(input logic [31:0] k);
        logic [4:0] r = 0;
        for (int i = 0; i < 6; i++) r ^= k[5*i +: 5];
        return r;
    endfunction
    function automatic logic [4:0] m_h2(input logic [31:0] k);
        logic [31:0] p = k * 32'h9E3779B1;
        return 5'(p >> 27);
    endfunction

    typedef struct packed {logic hit; logic tbl; logic [4:0] idx; logic [3:0] lat;} res_t;
    function automatic res_t m_lookup(input logic [31:0] k);
        logic [4:0] a = m_h1(k), b = m_h2(k);
        if (t1_fill[a] && t1_mem[a] == k) return '{1'b1, 1'b0, a, 4'd3};
        if (t2_fill[b] && t2_mem[b] == k) return '{1'b1, 1'b1, b, 4'd5};
        return '{1'b0, 1'b0, 5'd0, 4'd5};
    endfunction

    // Model: a lookup is busy from accept until the response handshake; ph is the cycle index since accept.
    logic        busy;
    int          ph;
    res_t        e;
    logic [4:0]  e_h1, e_h2;
    int          s_hits, s_miss;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 0; ph <= 0; s_hits <= 0; s_miss <= 0;
        end else if (!busy) begin
            if (req_valid) begin
                busy <= 1; ph <= 1; e <= m_lookup(req_key);
                e_h1 <= m_h1(req_key); e_h2 <= m_h2(req_key);
            end
        end else if (ph >= int'(e.lat) && rsp_ready) begin
            busy <= 0;
            if (e.hit) s_hits <= (s_hits == 65535) ? s_hits : s_hits + 1;
            else s_miss <= (s_miss == 65535) ? s_miss : s_miss + 1;
        end else begin
            ph <= ph + 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        vec++;
        if (a !== x) begin
            errs++;
            $display("FAIL %s got %0h want %0h (t=%0t)", n, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        logic rv, r1, r2;
        rv = busy && ph >= int'(e.lat);
        r1 = busy && ph == 1;
        r2 = busy && ph == 3 && e.lat == 4'd5;
        chk("req_ready", 32'(req_ready), 32'(!busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        chk("t1_rd_en", 32'(t1_rd_en), 32'(r1));
        chk("t1_raddr", 32'(t1_raddr), r1 ? 32'(e_h1) : 0);
        chk("t2_rd_en", 32'(t2_rd_en), 32'(r2));
        chk("t2_raddr", 32'(t2_raddr), r2 ? 32'(e_h2) : 0);
        if (rv || !rst_n) begin
            chk("rsp_hit", 32'(rsp_hit), rv ? 32'(e.hit) : 0);
            chk("rsp_tbl", 32'(rsp_tbl), rv ? 32'(e.tbl) : 0);
            chk("rsp_idx", 32'(rsp_idx), rv ? 32'(e.idx) : 0);
        end
`ifdef CUCKOO_LOOKUP_STATS_EN
        chk("stat_hits", 32'(stat_hits), 32'(s_hits));
        chk("stat_misses", 32'(stat_misses), 32'(s_miss));
`endif
    end

    logic       h, t;
    logic [4:0] ix;
    int         lat, wt;

    task automatic do_lookup(input logic [31:0] k, input int hold);
        @(negedge clk);
        req_valid = 1; req_key = k; rsp_ready = 0; wt = 0; h = 0; t = 0; ix = 0;
        while (!req_ready && wt < 20) begin @(negedge clk); wt++; end
        if (!req_ready) begin vec++; errs++; $display("FAIL accept timeout key=%0h", k); req_valid = 0; return; end
        @(posedge clk); #1 req_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        if (!rsp_valid) begin vec++; errs++; $display("FAIL response timeout key=%0h", k); return; end
        repeat (hold) @(negedge clk);
        h = rsp_hit; t = rsp_tbl; ix = rsp_idx; rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
    endtask

    task automatic expect_rsp(input string n, input logic xh, input logic xt, input logic [4:0] xi, input int xl);
        chk({n, ".hit"}, 32'(h), 32'(xh));
        chk({n, ".tbl"}, 32'(t), 32'(xt));
        chk({n, ".idx"}, 32'(ix), 32'(xi));
        chk({n, ".lat"}, 32'(lat), 32'(xl));
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 32; i++) begin t1_mem[i] = 0; t2_mem[i] = 0; t1_fill[i] = 0; t2_fill[i] = 0; end
    endtask

    initial begin
        clear_tables();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset rsp_valid", 32'(rsp_valid), 0);

        t1_mem[5] = 5; t1_fill[5] = 1;
        do_lookup(5, 0); expect_rsp("t1hit", 1, 0, 5, 3);

        t1_mem[5] = 7; t2_mem[2] = 5; t2_fill[2] = 1;
        do_lookup(5, 0); expect_rsp("t2hit", 1, 1, 2, 5);

        clear_tables();
        do_lookup(5, 0); expect_rsp("miss", 0, 0, 0, 5);

        t1_mem[5] = 5;
        do_lookup(5, 0); expect_rsp("unfilled", 0, 0, 0, 5);

        t1_fill[5] = 1;
        do_lookup(5, 10); expect_rsp("backpressure", 1, 0, 5, 3);
        do_lookup(5, 0);
        chk("b2b accept wait", 32'(wt), 0);
        expect_rsp("b2b", 1, 0, 5, 3);

        clear_tables();
        do_lookup(0, 0); expect_rsp("key0 empty", 0, 0, 0, 5);
        t2_fill[0] = 1;
        do_lookup(0, 0); expect_rsp("key0 t2", 1, 1, 0, 5);

        t2_mem[m_h2(32'h12345678)] = 32'h12345678; t2_fill[m_h2(32'h12345678)] = 1;
        do_lookup(32'h12345678, 2);
        chk("k12345678.hit", 32'(h), 1);
        chk("k12345678.tbl", 32'(t), 1);

        @(negedge clk); req_valid = 1; req_key = 5;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        chk("midreset rsp_valid", 32'(rsp_valid), 0);
        chk("midreset req_ready", 32'(req_ready), 1);
        @(posedge clk); #1 rst_n = 1;
        repeat (6) @(negedge clk);
        chk("after reset rsp_valid", 32'(rsp_valid), 0);

        clear_tables();
        t1_mem[5] = 5; t1_fill[5] = 1;
        do_lookup(5, 0);
        do_lookup(5, 1);
        do_lookup(9, 0); expect_rsp("stats miss", 0, 0, 0, 5);
        @(negedge clk);
`ifdef CUCKOO_LOOKUP_STATS_EN
        chk("stat_hits lit", 32'(stat_hits), 2);
        chk("stat_misses lit", 32'(stat_misses), 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
